// File: rtl/csr_unit.sv
// csr_unit -- machine-mode CSR file with interrupt arbitration, exception
// cause/tval capture, vectored mtvec and 64-bit cycle/instret counters.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   csr_addr -> data_out       combinational read port, csr_illegal flags
//                              unimplemented addresses
//   wr1_addr, data1_in, wcsr_n write port (active-low enable), data already
//                              merged for set/clear operations
//   Di_PC, tval_in             PC / faulting word of the trap-stage instruction
//   ecall, ebreak, illegal_inst, mret   single-cycle event pulses
//   instret                    one instruction retired this cycle
//   int_ok                     trap stage can accept an interrupt
//   irq_sw, irq_timer, irq_ext, irq_plat   level interrupt inputs
//   trap_taken, mret_taken, redirect_pc    fetch redirect (combinational)
//   irq_pending                (mip & mie) != 0
module csr_unit #(
  parameter int              XLEN         = 32,
  parameter int              NUM_IRQ      = 16,
  parameter logic [XLEN-1:0] MSCRATCH_RST = 32'h0802_0000,
  parameter logic [XLEN-1:0] MTVEC_RST    = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        csr_addr,
  output logic [XLEN-1:0]    data_out,
  output logic               csr_illegal,
  input  logic [11:0]        wr1_addr,
  input  logic [XLEN-1:0]    data1_in,
  input  logic               wcsr_n,
  input  logic [XLEN-1:0]    Di_PC,
  input  logic               ecall,
  input  logic               ebreak,
  input  logic               illegal_inst,
  input  logic               mret,
  input  logic [XLEN-1:0]    tval_in,
  input  logic               instret,
  input  logic               int_ok,
  input  logic               irq_sw,
  input  logic               irq_timer,
  input  logic               irq_ext,
  input  logic [NUM_IRQ-1:0] irq_plat,
  output logic               trap_taken,
  output logic               mret_taken,
  output logic [XLEN-1:0]    redirect_pc,
  output logic               irq_pending
);

  logic            mstatus_mie_reg, mstatus_mpie_reg;
  logic [XLEN-1:0] mie_reg, mtvec_reg, mscratch_reg, mepc_reg;
  logic [XLEN-1:0] mcause_reg, mtval_reg, mip_reg;
  logic [63:0]     mcycle_reg, minstret_reg;

  // mip_next samples the interrupt lines; irq_mask marks the bits that exist
  // so mie only ever holds enables for real sources.
  logic [XLEN-1:0] mip_next, irq_mask;

  for (genvar gi = 0; gi < XLEN; gi++) begin : g_irq_bits
    if (gi == 3) begin : g_sw
      assign mip_next[gi] = irq_sw;
      assign irq_mask[gi] = 1'b1;
    end else if (gi == 7) begin : g_timer
      assign mip_next[gi] = irq_timer;
      assign irq_mask[gi] = 1'b1;
    end else if (gi == 11) begin : g_ext
      assign mip_next[gi] = irq_ext;
      assign irq_mask[gi] = 1'b1;
    end else if (gi >= 16 && gi < 16 + NUM_IRQ) begin : g_plat
      assign mip_next[gi] = irq_plat[gi-16];
      assign irq_mask[gi] = 1'b1;
    end else begin : g_none
      assign mip_next[gi] = 1'b0;
      assign irq_mask[gi] = 1'b0;
    end
  end

  logic [XLEN-1:0] pend;
  logic [4:0]      irq_code;

  assign pend = mip_reg & mie_reg;

  // Fixed priority: ext > sw > timer > platform (lowest index wins, so scan
  // downward and let the last hit stand).
  always_comb begin
    irq_code = 5'd0;
    if (pend[11])     irq_code = 5'd11;
    else if (pend[3]) irq_code = 5'd3;
    else if (pend[7]) irq_code = 5'd7;
    else begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (pend[16+i]) irq_code = 5'(16 + i);
      end
    end
  end

  logic            exc, irq_take, trap, mret_act, wr_en;
  logic [4:0]      exc_code;
  logic [XLEN-1:0] trap_cause, trap_tval, trap_target, vec_off;

  assign exc      = illegal_inst | ebreak | ecall;
  assign irq_take = mstatus_mie_reg & int_ok & (|pend) & ~exc;
  assign trap     = (exc | irq_take) & ~reset;
  assign mret_act = mret & ~exc & ~irq_take & ~reset;
  // Any trap or mret in the same cycle swallows the CSR write.
  assign wr_en    = ~wcsr_n & ~exc & ~irq_take & ~mret;

  always_comb begin
    exc_code = 5'd11;
    if (illegal_inst) exc_code = 5'd2;
    else if (ebreak)  exc_code = 5'd3;
  end

  always_comb begin
    trap_cause             = '0;
    trap_cause[4:0]        = irq_take ? irq_code : exc_code;
    trap_cause[XLEN-1]     = irq_take;
  end

  assign trap_tval = illegal_inst ? tval_in : (ebreak ? Di_PC : '0);

  // Vectored mode (mtvec[1:0]==1) offsets interrupts only; modes 2/3 act direct.
  assign vec_off     = (mtvec_reg[1:0] == 2'b01 && irq_take) ? XLEN'({irq_code, 2'b00}) : '0;
  assign trap_target = {mtvec_reg[XLEN-1:2], 2'b00} + vec_off;

  assign trap_taken  = trap;
  assign mret_taken  = mret_act;
  assign redirect_pc = mret_act ? mepc_reg : trap_target;
  assign irq_pending = (|pend) & ~reset;

  always_comb begin
    data_out    = '0;
    csr_illegal = 1'b0;
    case (csr_addr)
      12'h300: begin
        data_out[3]     = mstatus_mie_reg;
        data_out[7]     = mstatus_mpie_reg;
        data_out[12:11] = 2'b11;
      end
      12'h304: data_out = mie_reg;
      12'h305: data_out = mtvec_reg;
      12'h340: data_out = mscratch_reg;
      12'h341: data_out = mepc_reg;
      12'h342: data_out = mcause_reg;
      12'h343: data_out = mtval_reg;
      12'h344: data_out = mip_reg;
      12'hB00, 12'hC00: data_out = XLEN'(mcycle_reg[31:0]);
      12'hB80, 12'hC80: data_out = XLEN'(mcycle_reg[63:32]);
      12'hB02, 12'hC02: data_out = XLEN'(minstret_reg[31:0]);
      12'hB82, 12'hC82: data_out = XLEN'(minstret_reg[63:32]);
      default: csr_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_reg  <= 1'b0;
      mstatus_mpie_reg <= 1'b0;
      mie_reg          <= '0;
      mtvec_reg        <= MTVEC_RST;
      mscratch_reg     <= MSCRATCH_RST;
      mepc_reg         <= '0;
      mcause_reg       <= '0;
      mtval_reg        <= '0;
      mip_reg          <= '0;
      mcycle_reg       <= '0;
      minstret_reg     <= '0;
    end else begin
      mip_reg      <= mip_next;
      mcycle_reg   <= mcycle_reg + 64'd1;
      minstret_reg <= minstret_reg + 64'(instret);
      if (trap) begin
        mepc_reg         <= {Di_PC[XLEN-1:2], 2'b00};
        mcause_reg       <= trap_cause;
        mtval_reg        <= trap_tval;
        mstatus_mpie_reg <= mstatus_mie_reg;
        mstatus_mie_reg  <= 1'b0;
      end else if (mret_act) begin
        mstatus_mie_reg  <= mstatus_mpie_reg;
        mstatus_mpie_reg <= 1'b1;
      end else if (wr_en) begin
        // A counter-half write supersedes that cycle's increment entirely.
        case (wr1_addr)
          12'h300: begin
            mstatus_mie_reg  <= data1_in[3];
            mstatus_mpie_reg <= data1_in[7];
          end
          12'h304: mie_reg      <= data1_in & irq_mask;
          12'h305: mtvec_reg    <= data1_in;
          12'h340: mscratch_reg <= data1_in;
          12'h341: mepc_reg     <= {data1_in[XLEN-1:2], 2'b00};
          12'h342: mcause_reg   <= data1_in;
          12'h343: mtval_reg    <= data1_in;
          12'hB00: mcycle_reg   <= {mcycle_reg[63:32], data1_in[31:0]};
          12'hB80: mcycle_reg   <= {data1_in[31:0], mcycle_reg[31:0]};
          12'hB02: minstret_reg <= {minstret_reg[63:32], data1_in[31:0]};
          12'hB82: minstret_reg <= {data1_in[31:0], minstret_reg[31:0]};
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed testbench for csr_unit. Inputs change on the falling edge and
// outputs are sampled 1 ns later, so every observation sits away from the
// rising edge. Each task starts and ends just after a falling edge.
`timescale 1ns/1ps
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [31:0] data_out;
  logic        csr_illegal;
  logic [11:0] wr1_addr;
  logic [31:0] data1_in;
  logic        wcsr_n;
  logic [31:0] Di_PC;
  logic        ecall, ebreak, illegal_inst, mret;
  logic [31:0] tval_in;
  logic        instret, int_ok;
  logic        irq_sw, irq_timer, irq_ext;
  logic [15:0] irq_plat;
  logic        trap_taken, mret_taken;
  logic [31:0] redirect_pc;
  logic        irq_pending;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk(clk), .reset(reset),
    .csr_addr(csr_addr), .data_out(data_out), .csr_illegal(csr_illegal),
    .wr1_addr(wr1_addr), .data1_in(data1_in), .wcsr_n(wcsr_n),
    .Di_PC(Di_PC), .ecall(ecall), .ebreak(ebreak), .illegal_inst(illegal_inst),
    .mret(mret), .tval_in(tval_in), .instret(instret), .int_ok(int_ok),
    .irq_sw(irq_sw), .irq_timer(irq_timer), .irq_ext(irq_ext), .irq_plat(irq_plat),
    .trap_taken(trap_taken), .mret_taken(mret_taken), .redirect_pc(redirect_pc),
    .irq_pending(irq_pending)
  );

  // Stimulus helpers only: present an address and fetch the read data, or
  // perform a one-cycle write. Comparisons live in the test tasks.
  task automatic csr_read(input logic [11:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = data_out;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    wr1_addr = a;
    data1_in = d;
    wcsr_n   = 1'b0;
    @(negedge clk);
    wcsr_n   = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    ecall = 1'b1;
    mret  = 1'b1;
    #1;
    checks++;
    if (trap_taken !== 1'b0) begin errors++; $display("FAIL reset_trap got %b expected 0", trap_taken); end
    checks++;
    if (mret_taken !== 1'b0) begin errors++; $display("FAIL reset_mret got %b expected 0", mret_taken); end
    checks++;
    if (irq_pending !== 1'b0) begin errors++; $display("FAIL reset_irqp got %b expected 0", irq_pending); end
    ecall = 1'b0;
    mret  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    csr_read(12'hB00, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_mcycle got %h expected 00000000", rd); end
    csr_read(12'h300, rd);
    checks++;
    if (rd !== 32'h0000_1800) begin errors++; $display("FAIL reset_mstatus got %h expected 00001800", rd); end
    csr_read(12'h340, rd);
    checks++;
    if (rd !== 32'h0802_0000) begin errors++; $display("FAIL reset_mscratch got %h expected 08020000", rd); end
    csr_read(12'h305, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_mtvec got %h expected 00000000", rd); end
    @(negedge clk);
    csr_read(12'hB00, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL mcycle_first got %h expected 00000001", rd); end
    $display("test_reset done");
  endtask

  task automatic test_ecall_mret;
    csr_write(12'h300, 32'h8);
    csr_write(12'h305, 32'h200);
    Di_PC = 32'h100;
    ecall = 1'b1;
    #1;
    checks++;
    if (trap_taken !== 1'b1) begin errors++; $display("FAIL ecall_trap got %b expected 1", trap_taken); end
    checks++;
    if (redirect_pc !== 32'h200) begin errors++; $display("FAIL ecall_pc got %h expected 00000200", redirect_pc); end
    @(negedge clk);
    ecall = 1'b0;
    csr_read(12'h341, rd);
    checks++;
    if (rd !== 32'h100) begin errors++; $display("FAIL ecall_mepc got %h expected 00000100", rd); end
    csr_read(12'h342, rd);
    checks++;
    if (rd !== 32'd11) begin errors++; $display("FAIL ecall_mcause got %h expected 0000000b", rd); end
    csr_read(12'h343, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL ecall_mtval got %h expected 00000000", rd); end
    csr_read(12'h300, rd);
    checks++;
    if (rd !== 32'h0000_1880) begin errors++; $display("FAIL ecall_mstatus got %h expected 00001880", rd); end
    @(negedge clk);
    mret = 1'b1;
    #1;
    checks++;
    if (mret_taken !== 1'b1 || trap_taken !== 1'b0) begin errors++; $display("FAIL mret_flags got %b%b expected 10", mret_taken, trap_taken); end
    checks++;
    if (redirect_pc !== 32'h100) begin errors++; $display("FAIL mret_pc got %h expected 00000100", redirect_pc); end
    @(negedge clk);
    mret = 1'b0;
    csr_read(12'h300, rd);
    checks++;
    if (rd !== 32'h0000_1888) begin errors++; $display("FAIL mret_mstatus got %h expected 00001888", rd); end
    $display("test_ecall_mret done");
  endtask

  task automatic test_irq_vectored;
    csr_write(12'h304, 32'h888);
    csr_write(12'h305, 32'h201);
    int_ok    = 1'b0;
    irq_timer = 1'b1;
    irq_ext   = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (irq_pending !== 1'b1) begin errors++; $display("FAIL irq_pending got %b expected 1", irq_pending); end
    checks++;
    if (trap_taken !== 1'b0) begin errors++; $display("FAIL irq_intok0 got %b expected 0", trap_taken); end
    int_ok = 1'b1;
    Di_PC  = 32'h300;
    #1;
    checks++;
    if (trap_taken !== 1'b1) begin errors++; $display("FAIL irq_trap got %b expected 1", trap_taken); end
    checks++;
    if (redirect_pc !== 32'h22C) begin errors++; $display("FAIL irq_vec_pc got %h expected 0000022c", redirect_pc); end
    @(negedge clk);
    int_ok    = 1'b0;
    irq_timer = 1'b0;
    irq_ext   = 1'b0;
    csr_read(12'h342, rd);
    checks++;
    if (rd !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause got %h expected 8000000b", rd); end
    csr_read(12'h341, rd);
    checks++;
    if (rd !== 32'h300) begin errors++; $display("FAIL irq_mepc got %h expected 00000300", rd); end
    csr_read(12'h343, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL irq_mtval got %h expected 00000000", rd); end
    csr_read(12'h300, rd);
    checks++;
    if (rd !== 32'h0000_1880) begin errors++; $display("FAIL irq_mstatus got %h expected 00001880", rd); end
    // Lines dropped before being taken: nothing must remain pending.
    csr_write(12'h300, 32'h8);
    int_ok = 1'b1;
    #1;
    checks++;
    if (trap_taken !== 1'b0 || irq_pending !== 1'b0) begin errors++; $display("FAIL irq_cancel got %b%b expected 00", trap_taken, irq_pending); end
    int_ok = 1'b0;
    $display("test_irq_vectored done");
  endtask

  task automatic test_irq_arbitration;
    csr_write(12'h304, 32'h0001_0008);
    csr_write(12'h305, 32'h200);
    irq_sw   = 1'b1;
    irq_plat = 16'h0005;
    @(negedge clk);
    int_ok = 1'b1;
    #1;
    checks++;
    if (trap_taken !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL arb_sw got %b/%h expected 1/00000200", trap_taken, redirect_pc); end
    @(negedge clk);
    int_ok   = 1'b0;
    irq_sw   = 1'b0;
    irq_plat = 16'h0;
    csr_read(12'h342, rd);
    checks++;
    if (rd !== 32'h8000_0003) begin errors++; $display("FAIL arb_sw_cause got %h expected 80000003", rd); end
    csr_write(12'h304, 32'h0006_0000);
    csr_write(12'h305, 32'h201);
    csr_write(12'h300, 32'h8);
    irq_plat = 16'h0006;
    @(negedge clk);
    int_ok = 1'b1;
    #1;
    checks++;
    if (trap_taken !== 1'b1 || redirect_pc !== 32'h244) begin errors++; $display("FAIL arb_plat got %b/%h expected 1/00000244", trap_taken, redirect_pc); end
    @(negedge clk);
    int_ok   = 1'b0;
    irq_plat = 16'h0;
    csr_read(12'h342, rd);
    checks++;
    if (rd !== 32'h8000_0011) begin errors++; $display("FAIL arb_plat_cause got %h expected 80000011", rd); end
    $display("test_irq_arbitration done");
  endtask

  task automatic test_exc_priority;
    @(negedge clk);
    illegal_inst = 1'b1;
    ecall        = 1'b1;
    tval_in      = 32'hDEAD_BEEF;
    Di_PC        = 32'h400;
    wr1_addr     = 12'h340;
    data1_in     = 32'h1234_5678;
    wcsr_n       = 1'b0;
    #1;
    checks++;
    if (trap_taken !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL ill_trap got %b/%h expected 1/00000200", trap_taken, redirect_pc); end
    @(negedge clk);
    illegal_inst = 1'b0;
    ecall        = 1'b0;
    wcsr_n       = 1'b1;
    csr_read(12'h342, rd);
    checks++;
    if (rd !== 32'd2) begin errors++; $display("FAIL ill_mcause got %h expected 00000002", rd); end
    csr_read(12'h343, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ill_mtval got %h expected deadbeef", rd); end
    csr_read(12'h340, rd);
    checks++;
    if (rd !== 32'h0802_0000) begin errors++; $display("FAIL ill_mscratch got %h expected 08020000", rd); end
    @(negedge clk);
    ebreak = 1'b1;
    ecall  = 1'b1;
    Di_PC  = 32'h404;
    @(negedge clk);
    ebreak = 1'b0;
    ecall  = 1'b0;
    csr_read(12'h342, rd);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL ebrk_mcause got %h expected 00000003", rd); end
    csr_read(12'h343, rd);
    checks++;
    if (rd !== 32'h404) begin errors++; $display("FAIL ebrk_mtval got %h expected 00000404", rd); end
    @(negedge clk);
    mret     = 1'b1;
    wr1_addr = 12'h340;
    data1_in = 32'h1111;
    wcsr_n   = 1'b0;
    #1;
    checks++;
    if (mret_taken !== 1'b1 || redirect_pc !== 32'h404) begin errors++; $display("FAIL mret_wr got %b/%h expected 1/00000404", mret_taken, redirect_pc); end
    @(negedge clk);
    mret   = 1'b0;
    wcsr_n = 1'b1;
    csr_read(12'h340, rd);
    checks++;
    if (rd !== 32'h0802_0000) begin errors++; $display("FAIL mret_drop got %h expected 08020000", rd); end
    csr_write(12'h341, 32'h123);
    csr_read(12'h341, rd);
    checks++;
    if (rd !== 32'h120) begin errors++; $display("FAIL mepc_align got %h expected 00000120", rd); end
    $display("test_exc_priority done");
  endtask

  task automatic test_counters;
    @(negedge clk);
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'hFFFF_FFFF);
    @(negedge clk);
    csr_read(12'hB00, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_lo got %h expected 00000000", rd); end
    csr_read(12'hB80, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_hi got %h expected 00000000", rd); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      instret = 1'b1;
      @(negedge clk);
    end
    instret = 1'b0;
    csr_read(12'hB02, rd);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL minstret got %h expected 00000003", rd); end
    csr_read(12'hC02, rd);
    checks++;
    if (rd !== 32'd3) begin errors++; $display("FAIL minstret_shadow got %h expected 00000003", rd); end
    csr_read(12'hB82, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL minstreth got %h expected 00000000", rd); end
    $display("test_counters done");
  endtask

  task automatic test_mip_illegal;
    @(negedge clk);
    irq_sw   = 1'b1;
    irq_plat = 16'h0001;
    @(negedge clk);
    csr_write(12'h344, 32'hFFFF_FFFF);
    csr_read(12'h344, rd);
    checks++;
    if (rd !== 32'h0001_0008) begin errors++; $display("FAIL mip_ro got %h expected 00010008", rd); end
    checks++;
    if (csr_illegal !== 1'b0) begin errors++; $display("FAIL mip_legal got %b expected 0", csr_illegal); end
    csr_read(12'h7C0, rd);
    checks++;
    if (rd !== 32'h0 || csr_illegal !== 1'b1) begin errors++; $display("FAIL unimpl got %h/%b expected 00000000/1", rd, csr_illegal); end
    irq_sw   = 1'b0;
    irq_plat = 16'h0;
    $display("test_mip_illegal done");
  endtask

  task automatic test_reset_mid_trap;
    @(negedge clk);
    csr_write(12'h340, 32'h55);
    csr_read(12'h340, rd);
    checks++;
    if (rd !== 32'h55) begin errors++; $display("FAIL mscratch_wr got %h expected 00000055", rd); end
    @(negedge clk);
    ecall = 1'b1;
    Di_PC = 32'h500;
    reset = 1'b1;
    #1;
    checks++;
    if (trap_taken !== 1'b0) begin errors++; $display("FAIL rst_trap got %b expected 0", trap_taken); end
    @(negedge clk);
    reset = 1'b0;
    ecall = 1'b0;
    csr_read(12'h341, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_mepc got %h expected 00000000", rd); end
    csr_read(12'h340, rd);
    checks++;
    if (rd !== 32'h0802_0000) begin errors++; $display("FAIL rst_mscratch got %h expected 08020000", rd); end
    csr_read(12'h300, rd);
    checks++;
    if (rd !== 32'h0000_1800) begin errors++; $display("FAIL rst_mstatus got %h expected 00001800", rd); end
    csr_read(12'h342, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL rst_mcause got %h expected 00000000", rd); end
    $display("test_reset_mid_trap done");
  endtask

  initial begin
    reset = 1'b1; csr_addr = '0; wr1_addr = '0; data1_in = '0; wcsr_n = 1'b1;
    Di_PC = '0; ecall = 1'b0; ebreak = 1'b0; illegal_inst = 1'b0; mret = 1'b0;
    tval_in = '0; instret = 1'b0; int_ok = 1'b0;
    irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0; irq_plat = '0;
    test_reset();
    test_ecall_mret();
    test_irq_vectored();
    test_irq_arbitration();
    test_exc_priority();
    test_counters();
    test_mip_illegal();
    test_reset_mid_trap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
